// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end and its consumers.
// The bit indices fix how BTN[6:0] and BTN_7 are packed into one vector.
package btn_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int N_BTN_DEF       = 8;
    localparam int DB_CYCLES_DEF   = 1_000_000;   // 20 ms at CLK_HZ
    localparam int HOLD_CYCLES_DEF = 50_000_000;  // 1 s at CLK_HZ

    typedef enum logic [2:0] {
        BTN0_IDX = 3'd0,
        BTN1_IDX = 3'd1,
        BTN2_IDX = 3'd2,
        BTN3_IDX = 3'd3,
        BTN4_IDX = 3'd4,
        BTN5_IDX = 3'd5,
        BTN6_IDX = 3'd6,
        BTN7_IDX = 3'd7
    } btn_idx_e;

    function automatic int cycles_from_ms(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button bundle between the raw pad side (master) and the debouncer (slave).
interface btn_debounce_pulse_if
    import btn_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_hold;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_hold
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_hold
    );

endinterface

// File: rtl/btn_debounce_cell.sv
// One button channel: 2-flop synchroniser, debounce counter, hold counter
// and registered press/release/hold strobes.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

    logic              r_sync_p0;
    logic              r_sync_p1;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_hold;

    logic w_diff;
    logic w_accept;

    assign w_diff   = r_sync_p1 ^ r_level;
    assign w_accept = w_diff && (r_db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0  <= 1'b0;
            r_sync_p1  <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;

            // Any sample matching the current level restarts the stability count.
            if (!w_diff) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt <= '0;
                r_level  <= r_sync_p1;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            r_press   <= w_accept &&  r_sync_p1;
            r_release <= w_accept && !r_sync_p1;

            // Saturating count of cycles since the press; one hold strobe per press.
            if (!r_level) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != HOLD_SAT) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end

            // A release accepted on the hold edge wins over the hold strobe.
            r_hold <= r_level && (r_hold_cnt == HOLD_LAST) && !w_accept;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Input conditioning for the selecting machine: N_BTN independent
// debounce channels driving clean levels and press/release/hold strobes.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_pulse_if.slave  bus
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_cell #(
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (bus.btn_raw[gi]),
            .o_level   (bus.btn_level[gi]),
            .o_press   (bus.btn_press[gi]),
            .o_release (bus.btn_release[gi]),
            .o_hold    (bus.btn_hold[gi])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with short debounce/hold times.
module tb_btn_debounce_pulse;

    localparam int NB   = 8;
    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int chk = 0;
    int err = 0;
    int cyc = 0;

    btn_debounce_pulse_if #(.N_BTN(NB)) bus ();

    btn_debounce_pulse #(
        .N_BTN       (NB),
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips after DB consecutive synchronised samples
    // that disagree with it; hold is due HOLD edges after the press edge.
    bit         m_s1    [NB];
    bit         m_s2    [NB];
    bit         m_lvl   [NB];
    int         m_run   [NB];
    int         m_since [NB];
    logic [NB-1:0] e_level   = '0;
    logic [NB-1:0] e_press   = '0;
    logic [NB-1:0] e_release = '0;
    logic [NB-1:0] e_hold    = '0;

    always @(posedge clk) begin
        bit smp;
        cyc++;
        for (int i = 0; i < NB; i++) begin
            e_press[i]   = 1'b0;
            e_release[i] = 1'b0;
            e_hold[i]    = 1'b0;
            if (rst) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_since[i] = 0;
            end else begin
                smp     = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = bus.btn_raw[i];
                if (smp != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = smp;
                        m_run[i] = 0;
                        if (smp) e_press[i] = 1'b1;
                        else     e_release[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (e_press[i]) m_since[i] = 0;
                else if (m_lvl[i]) m_since[i]++;
                e_hold[i] = m_lvl[i] && (m_since[i] == HOLD);
            end
            e_level[i] = m_lvl[i];
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_raw = '0;
        for (int c = 0; c < 53; c++) begin
            if (c == 3) rst = 1'b0;
            @(posedge clk); #1;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !== 32'h0) begin
                err++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=00000000", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold});
            end
        end
    endtask

    task automatic test_clean_press();
        int k = 0, pc = -1, np = 0;
        bus.btn_raw = 8'h01;
        for (int c = 0; c < 24; c++) begin
            if (c == 12) bus.btn_raw = 8'h00;
            @(posedge clk); #1;
            if (c == 0) k = cyc;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL clean_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
            if (bus.btn_press[0]) begin np++; if (pc < 0) pc = cyc; end
            if (c == 11) begin
                chk++;
                if (bus.btn_level !== 8'h01) begin
                    err++;
                    $display("FAIL clean_level got=%h exp=01", bus.btn_level);
                end
            end
        end
        chk++;
        if (pc !== k + 5) begin
            err++;
            $display("FAIL clean_latency got=%0d exp=%0d", pc - k, 5);
        end
        chk++;
        if (np !== 1) begin
            err++;
            $display("FAIL clean_press_count got=%0d exp=1", np);
        end
    endtask

    task automatic test_bounce();
        int nstr = 0, np = 0;
        int lvl_seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (c < 24) bus.btn_raw = ((c % 4) == 3) ? 8'h00 : 8'h08;
            else if (c < 36) bus.btn_raw = 8'h08;
            else bus.btn_raw = 8'h00;
            @(posedge clk); #1;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL bounce_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
            if (c < 26) begin
                if (bus.btn_level[3] || bus.btn_press[3] || bus.btn_release[3] || bus.btn_hold[3])
                    nstr++;
                lvl_seen++;
            end else if (bus.btn_press[3]) begin
                np++;
            end
        end
        chk++;
        if (nstr !== 0) begin
            err++;
            $display("FAIL bounce_reject got=%0d active cycles exp=0 of %0d", nstr, lvl_seen);
        end
        chk++;
        if (np !== 1) begin
            err++;
            $display("FAIL bounce_stable_press got=%0d exp=1", np);
        end
    endtask

    task automatic test_hold_release();
        int k = 0, l = 0, pc = -1, hc = -1, rc = -1, nh = 0, nr = 0, np = 0;
        bus.btn_raw = 8'h80;
        for (int c = 0; c < 65; c++) begin
            if (c == 40) bus.btn_raw = 8'h00;
            @(posedge clk); #1;
            if (c == 0) k = cyc;
            if (c == 40) l = cyc;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL hold_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
            if (bus.btn_press[7])   begin np++; if (pc < 0) pc = cyc; end
            if (bus.btn_hold[7])    begin nh++; if (hc < 0) hc = cyc; end
            if (bus.btn_release[7]) begin nr++; if (rc < 0) rc = cyc; end
        end
        chk++;
        if (pc !== k + 5 || np !== 1) begin
            err++;
            $display("FAIL hold_press got=+%0d x%0d exp=+5 x1", pc - k, np);
        end
        chk++;
        if (hc !== pc + HOLD) begin
            err++;
            $display("FAIL hold_time got=+%0d exp=+%0d", hc - pc, HOLD);
        end
        chk++;
        if (nh !== 1) begin
            err++;
            $display("FAIL hold_once got=%0d exp=1", nh);
        end
        chk++;
        if (rc !== l + 5 || nr !== 1) begin
            err++;
            $display("FAIL hold_release got=+%0d x%0d exp=+5 x1", rc - l, nr);
        end
    endtask

    task automatic test_short_press();
        int np = 0, nr = 0, nh = 0;
        bus.btn_raw = 8'h04;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) bus.btn_raw = 8'h00;
            @(posedge clk); #1;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL short_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
            np += bus.btn_press[2];
            nr += bus.btn_release[2];
            nh += bus.btn_hold[2];
        end
        chk++;
        if (np !== 1 || nr !== 1 || nh !== 0) begin
            err++;
            $display("FAIL short_counts got=press%0d/rel%0d/hold%0d exp=1/1/0", np, nr, nh);
        end
    endtask

    task automatic test_multi_reset();
        int r = 0, p0 = -1, p7 = -1, bad = 0;
        bus.btn_raw = 8'h81;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            @(posedge clk); #1;
            if (c == 4) r = cyc;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL multi_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
            if (c < 4 && (bus.btn_press | bus.btn_release | bus.btn_hold) != 8'h00) bad++;
            if (bus.btn_press[0] && p0 < 0) p0 = cyc;
            if (bus.btn_press[7] && p7 < 0) p7 = cyc;
        end
        chk++;
        if (bad !== 0) begin
            err++;
            $display("FAIL multi_no_strobe_in_reset got=%0d exp=0", bad);
        end
        chk++;
        if (p0 !== r + 5 || p7 !== r + 5) begin
            err++;
            $display("FAIL multi_press_sync got=+%0d/+%0d exp=+5/+5", p0 - r, p7 - r);
        end
        bus.btn_raw = 8'h00;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] raw = '0;
        int nrst = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 23) == 0) raw[i] = ~raw[i];
            end
            bus.btn_raw = raw;
            if (nrst > 0) nrst--;
            else if ($urandom_range(0, 499) == 0) nrst = $urandom_range(1, 3);
            rst = (nrst > 0);
            @(posedge clk); #1;
            chk++;
            if ({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold} !==
                {e_level, e_press, e_release, e_hold}) begin
                err++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc,
                         {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_hold},
                         {e_level, e_press, e_release, e_hold});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.btn_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_release();
        test_short_press();
        test_multi_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
